// File: rtl/config_pkg.sv
// Active floating-point configuration shared by the FMA pipeline blocks.
// Double precision: 11-bit exponent, 52-bit fraction, 106-bit product/sum.
package config_pkg;

  localparam int NE     = 11;
  localparam int NF     = 52;
  localparam int FMALEN = 2 * (NF + 1);

endpackage

// File: rtl/fma_norm_seq_pkg.sv
// Shared types for the sequential FMA sum normalizer.
// The pass-through fields travel with the operand but are never shifted.
package fma_norm_seq_pkg;

  import config_pkg::*;

  typedef struct packed {
    logic [NE+1:0] exp;
    logic          zero;
    logic          subnorm;
  } norm_meta_t;

endpackage

// File: rtl/fma_norm_seq_if.sv
// Handshake and data bundle between the shift calculation, the normalizer
// and its consumer. The master drives operands; the slave is the normalizer.
interface fma_norm_seq_if;

  import config_pkg::*;

  localparam int SW = $clog2(FMALEN + 1);

  logic              Flush;
  logic              InValid;
  logic              InReady;
  logic [FMALEN-1:0] FmaSm;
  logic [SW-1:0]     FmaShiftAmt;
  logic [NE+1:0]     NormSumExp;
  logic              FmaSZero;
  logic              FmaPreResultSubnorm;
  logic              OutValid;
  logic              OutReady;
  logic [FMALEN-1:0] Shifted;
  logic [NE+1:0]     ShiftedExp;
  logic              ShiftedZero;
  logic              ShiftedSubnorm;

  modport master (
    output Flush, InValid, FmaSm, FmaShiftAmt, NormSumExp, FmaSZero,
           FmaPreResultSubnorm, OutReady,
    input  InReady, OutValid, Shifted, ShiftedExp, ShiftedZero, ShiftedSubnorm
  );

  modport slave (
    input  Flush, InValid, FmaSm, FmaShiftAmt, NormSumExp, FmaSZero,
           FmaPreResultSubnorm, OutReady,
    output InReady, OutValid, Shifted, ShiftedExp, ShiftedZero, ShiftedSubnorm
  );

endinterface

// File: rtl/fma_norm_step.sv
// One cycle's worth of left shift; the caller guarantees k never exceeds STEP.
// Zeros enter from the LSB and bits leaving the MSB are dropped.
module fma_norm_step #(
  parameter int W  = 106,
  parameter int KW = 5
) (
  input  logic [W-1:0]  data,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  result
);

  assign result = data << k;

endmodule

// File: rtl/fma_norm_seq.sv
// Multi-cycle normalizer: left-shifts the FMA sum by up to STEP bits per
// cycle until the requested count is consumed, then holds the result.
module fma_norm_seq
  import config_pkg::*;
  import fma_norm_seq_pkg::*;
#(
  parameter int STEPLOG2 = 4
) (
  input logic          clk,
  input logic          reset,
  fma_norm_seq_if.slave bus
);

  localparam int STEP = 2 ** STEPLOG2;
  localparam int SW   = $clog2(FMALEN + 1);
  localparam int KW   = STEPLOG2 + 1;
  localparam int RW   = (SW > KW) ? SW : KW;

  localparam logic [RW-1:0] STEP_R = RW'(STEP);
  localparam logic [RW-1:0] LEN_R  = RW'(FMALEN);
  localparam logic [KW-1:0] STEP_K = KW'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              last_step;
  logic [FMALEN-1:0] data_q;
  logic [FMALEN-1:0] step_out;
  logic [RW-1:0]     rem_q;
  logic [RW-1:0]     amt_ext;
  logic [RW-1:0]     amt_clamped;
  logic [KW-1:0]     k;
  norm_meta_t        meta_q;
  norm_meta_t        meta_in;

  // Counts beyond FMALEN are clamped so the walk always ends in a few steps.
  assign amt_ext     = RW'(bus.FmaShiftAmt);
  assign amt_clamped = (amt_ext > LEN_R) ? LEN_R : amt_ext;
  assign k           = (rem_q > STEP_R) ? STEP_K : rem_q[KW-1:0];
  assign last_step   = (rem_q <= STEP_R);

  assign meta_in.exp     = bus.NormSumExp;
  assign meta_in.zero    = bus.FmaSZero;
  assign meta_in.subnorm = bus.FmaPreResultSubnorm;

  fma_norm_step #(
    .W  (FMALEN),
    .KW (KW)
  ) u_step (
    .data   (data_q),
    .k      (k),
    .result (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Flush overrides every other transition, including a pending handoff.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.InValid && !bus.Flush) begin
          accept     = 1'b1;
          next_state = bus.FmaSZero ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (bus.OutReady) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (bus.Flush) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      rem_q  <= '0;
      meta_q <= '0;
    end else if (accept) begin
      data_q <= bus.FmaSZero ? '0 : bus.FmaSm;
      rem_q  <= amt_clamped;
      meta_q <= meta_in;
    end else if (state == SHIFT && !bus.Flush) begin
      data_q <= step_out;
      rem_q  <= rem_q - RW'(k);
    end
  end

  assign bus.InReady        = (state == IDLE);
  assign bus.OutValid       = (state == DONE);
  assign bus.Shifted        = data_q;
  assign bus.ShiftedExp     = meta_q.exp;
  assign bus.ShiftedZero    = meta_q.zero;
  assign bus.ShiftedSubnorm = meta_q.subnorm;

endmodule
